// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and constants for the MIPS pipeline hazard controller.
// Latency: n/a (types, constants and a pure compare helper only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  localparam int MD_CNT_W = 6;

  // $zero is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_timer.sv
// Purpose: mul/div occupancy timer for the E stage (IDLE/BUSY FSM + 6-bit down-counter).
// Latency: md_busy/md_done are combinational from state and inputs; state updates each edge.
// Backpressure: the counter keeps running under mem_stall; completion is held off until mem_stall drops.
module md_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_i,
  input  logic md_div_i,
  input  logic mem_stall_i,
  output logic md_busy_o,
  output logic md_done_o
);

  // The start cycle counts as the first stall cycle, so the counter loads N-1.
  localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_CYCLES - 1);

  md_state_t             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  // Next-state and stall/done decode; reset low forces both outputs off.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_busy_o = 1'b0;
    md_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_start_i && !mem_stall_i) begin
          md_busy_o = 1'b1;
          cnt_d     = md_div_i ? DIV_LOAD : MUL_LOAD;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          md_busy_o = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end else if (!mem_stall_i) begin
          // E advances at this edge, so a still-high md_start belongs to the finished op.
          md_done_o = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      md_busy_o = 1'b0;
      md_done_o = 1'b0;
    end
  end

  // State and counter registers with synchronous active-low reset (aborts any op silently).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: 5-stage MIPS hazard controller: stage enables/clears, D/E forwarding, mul/div stalls, perf counters.
// Latency: all controls combinational from inputs and timer state; counters update one edge later.
// Backpressure: mem_stall freezes every stage; optional counters enabled by macro PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [4:0]  rs_e,
  input  logic [4:0]  rt_e,
  input  logic [4:0]  write_reg_e,
  input  logic [4:0]  write_reg_m,
  input  logic [4:0]  write_reg_w,
  input  logic        regwrite_e,
  input  logic        regwrite_m,
  input  logic        regwrite_w,
  input  logic        memtoreg_e,
  input  logic        memtoreg_m,
  input  logic        branch_d,
  input  logic        pc_redirect_d,
  input  logic        md_start_e,
  input  logic        md_div_e,
  input  logic        mem_stall,
  output logic        en_f,
  output logic        en_d,
  output logic        en_e,
  output logic        en_m,
  output logic        en_w,
  output logic        clr_d,
  output logic        clr_e,
  output logic        clr_m,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        fwd_a_d,
  output logic        fwd_b_d,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic lwstall;
  logic brstall;

  md_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk         (clk),
    .reset       (reset),
    .md_start_i  (md_start_e),
    .md_div_i    (md_div_e),
    .mem_stall_i (mem_stall),
    .md_busy_o   (md_busy),
    .md_done_o   (md_done)
  );

  // Load-use and branch-compare dependencies on instructions still in flight.
  always_comb begin
    lwstall = memtoreg_e & (reg_match(write_reg_e, rs_d) | reg_match(write_reg_e, rt_d));
    brstall = branch_d &
              ((regwrite_e & (reg_match(write_reg_e, rs_d) | reg_match(write_reg_e, rt_d))) |
               (memtoreg_m & (reg_match(write_reg_m, rs_d) | reg_match(write_reg_m, rt_d))));
  end

  // Operand bypass selects; M is newer than W so it wins.
  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
    if (reset) begin
      if (regwrite_m && reg_match(write_reg_m, rs_e))      fwd_a_e = FWD_M;
      else if (regwrite_w && reg_match(write_reg_w, rs_e)) fwd_a_e = FWD_W;
      if (regwrite_m && reg_match(write_reg_m, rt_e))      fwd_b_e = FWD_M;
      else if (regwrite_w && reg_match(write_reg_w, rt_e)) fwd_b_e = FWD_W;
      fwd_a_d = regwrite_m & reg_match(write_reg_m, rs_d);
      fwd_b_d = regwrite_m & reg_match(write_reg_m, rt_d);
    end
  end

  // Priority mux for stage enables/clears: reset, freeze, mul/div, data hazard, redirect, run.
  always_comb begin
    en_f  = 1'b1;
    en_d  = 1'b1;
    en_e  = 1'b1;
    en_m  = 1'b1;
    en_w  = 1'b1;
    clr_d = 1'b0;
    clr_e = 1'b0;
    clr_m = 1'b0;
    if (!reset || mem_stall) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_e = 1'b0;
      en_m = 1'b0;
      en_w = 1'b0;
    end else if (md_busy) begin
      // Hold F/D/E around the mul/div and feed bubbles into M.
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      clr_m = 1'b1;
    end else if (lwstall || brstall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end else if (pc_redirect_d) begin
      clr_d = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic        stall_inc;
  logic        flush_inc;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_comb begin
    stall_inc = reset & ~en_f;
    flush_inc = (clr_d & en_d) | (clr_e & en_e) | (clr_m & en_m);
  end

  // Free-running wrap-around event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, stall_inc};
      flush_cnt_q <= flush_cnt_q + {31'd0, flush_inc};
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: scoreboard bench for pipe_hazard_ctrl driven by directed vectors.
// Latency: expectations are for the same cycle the vector is applied (combinational controls).
// Backpressure: n/a; counters expected only when PIPE_PERF_CNT_EN is defined, else 0.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wre, wrm, wrw;
    logic       rwe, rwm, rww, mte, mtm, br, redir, mds, mdd, mst;
  } in_t;

  typedef struct {
    logic       rst_n;
    logic [4:0] en;    // {f,d,e,m,w}
    logic [2:0] clr;   // {d,e,m}
    logic [1:0] fae, fbe;
    logic       fad, fbd, busy, done;
    bit         chk_busy;
    int         id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic        regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
  logic        branch_d, pc_redirect_d, md_start_e, md_div_e, mem_stall;
  logic        en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        fwd_a_d, fwd_b_d, md_busy, md_done;
  logic [31:0] stall_cnt, flush_cnt;

  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .branch_d(branch_d), .pc_redirect_d(pc_redirect_d),
    .md_start_e(md_start_e), .md_div_e(md_div_e), .mem_stall(mem_stall),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .clr_d(clr_d), .clr_e(clr_e), .clr_m(clr_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic in_t idle_in();
    in_t v;
    v = '{rst_n: 1'b1, default: '0};
    return v;
  endfunction

  function automatic exp_t e_base(input logic [4:0] en, input logic [2:0] clr);
    exp_t e;
    e.rst_n = 1'b1; e.en = en; e.clr = clr;
    e.fae = 2'd0; e.fbe = 2'd0; e.fad = 1'b0; e.fbd = 1'b0;
    e.busy = 1'b0; e.done = 1'b0; e.chk_busy = 1'b1; e.id = 0;
    return e;
  endfunction

  function automatic exp_t e_run();  return e_base(5'b11111, 3'b000); endfunction
  function automatic exp_t e_frz();  return e_base(5'b00000, 3'b000); endfunction
  function automatic exp_t e_hz();   return e_base(5'b00111, 3'b010); endfunction
  function automatic exp_t e_md();
    exp_t e;
    e = e_base(5'b00011, 3'b001);
    e.busy = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_rst();
    exp_t e;
    e = e_base(5'b00000, 3'b000);
    e.rst_n = 1'b0;
    return e;
  endfunction

  task automatic drive_in(input in_t v);
    reset = v.rst_n; rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e;
    write_reg_e = v.wre; write_reg_m = v.wrm; write_reg_w = v.wrw;
    regwrite_e = v.rwe; regwrite_m = v.rwm; regwrite_w = v.rww;
    memtoreg_e = v.mte; memtoreg_m = v.mtm; branch_d = v.br; pc_redirect_d = v.redir;
    md_start_e = v.mds; md_div_e = v.mdd; mem_stall = v.mst;
  endtask

  // One vector per cycle: drive just after the edge and queue its expectation.
  task automatic apply(input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    drive_in(v);
    e.id = vec_n;
    vec_n++;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, id, act, exp);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare mid-cycle.
  initial begin : monitor
    exp_t        e;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
    exp_stall = '0;
    exp_flush = '0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("en",      e.id, {27'd0, en_f, en_d, en_e, en_m, en_w}, {27'd0, e.en});
        chk("clr",     e.id, {29'd0, clr_d, clr_e, clr_m},          {29'd0, e.clr});
        chk("fwd_e",   e.id, {28'd0, fwd_a_e, fwd_b_e},             {28'd0, e.fae, e.fbe});
        chk("fwd_d",   e.id, {30'd0, fwd_a_d, fwd_b_d},             {30'd0, e.fad, e.fbd});
        chk("md_done", e.id, {31'd0, md_done},                      {31'd0, e.done});
        if (e.chk_busy)
          chk("md_busy", e.id, {31'd0, md_busy}, {31'd0, e.busy});
        chk("stall_cnt", e.id, stall_cnt, exp_stall);
        chk("flush_cnt", e.id, flush_cnt, exp_flush);
`ifdef PIPE_PERF_CNT_EN
        if (!e.rst_n) begin
          exp_stall = '0;
          exp_flush = '0;
        end else begin
          if (!e.en[4]) exp_stall = exp_stall + 32'd1;
          if ((e.clr[2] & e.en[3]) | (e.clr[1] & e.en[2]) | (e.clr[0] & e.en[1]))
            exp_flush = exp_flush + 32'd1;
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    in_t  v;
    exp_t e;
    v = idle_in();
    v.rst_n = 1'b0;
    drive_in(v);

    // Reset: everything low, even with a live forwarding match.
    v.rwm = 1'b1; v.wrm = 5'd5; v.rs_e = 5'd5;
    apply(v, e_rst());
    apply(v, e_rst());
    apply(idle_in(), e_run());

    // E forwarding: M wins over W; $0 never forwards.
    v = idle_in(); v.rwm = 1; v.wrm = 5; v.rww = 1; v.wrw = 5; v.rs_e = 5;
    e = e_run(); e.fae = 2'd2; apply(v, e);
    v.rs_e = 0;
    apply(v, e_run());
    v = idle_in(); v.rwm = 1; v.wrm = 3; v.rww = 1; v.wrw = 7; v.rs_e = 3; v.rt_e = 7;
    e = e_run(); e.fae = 2'd2; e.fbe = 2'd1; apply(v, e);
    v = idle_in(); v.rwm = 1; v.rww = 1;
    apply(v, e_run());
    // D-comparator forwarding.
    v = idle_in(); v.rwm = 1; v.wrm = 9; v.rs_d = 9; v.rt_d = 9;
    e = e_run(); e.fad = 1; e.fbd = 1; apply(v, e);

    // Load-use: one bubble, then normal flow.
    v = idle_in(); v.mte = 1; v.wre = 2; v.rs_d = 2;
    apply(v, e_hz());
    apply(idle_in(), e_run());
    v = idle_in(); v.mte = 1; v.wre = 4; v.rt_d = 4;
    apply(v, e_hz());
    v = idle_in(); v.mte = 1;
    apply(v, e_run());

    // Branch compare hazards.
    v = idle_in(); v.br = 1; v.rwe = 1; v.wre = 6; v.rs_d = 6;
    apply(v, e_hz());
    v = idle_in(); v.br = 1; v.mtm = 1; v.wrm = 8; v.rt_d = 8;
    apply(v, e_hz());
    v = idle_in(); v.rwe = 1; v.wre = 6; v.rs_d = 6;
    apply(v, e_run());

    // Redirect vs load-use, then redirect alone.
    v = idle_in(); v.redir = 1; v.mte = 1; v.wre = 2; v.rs_d = 2;
    apply(v, e_hz());
    v = idle_in(); v.redir = 1;
    apply(v, e_base(5'b11111, 3'b100));

    // Memory stall freezes everything, overriding hazards.
    v = idle_in(); v.mst = 1;
    apply(v, e_frz());
    v.mte = 1; v.wre = 2; v.rs_d = 2; v.redir = 1;
    apply(v, e_frz());

    // Multiply: 4 stall cycles, done in cycle 5, redirect+lwstall suppressed.
    v = idle_in(); v.mds = 1;
    apply(v, e_md());
    v.redir = 1; v.mte = 1; v.wre = 2; v.rs_d = 2;
    apply(v, e_md());
    v = idle_in(); v.mds = 1;
    apply(v, e_md());
    apply(v, e_md());
    e = e_run(); e.done = 1; apply(v, e);
    apply(idle_in(), e_run());

    // Divide with mem_stall in cycles 30-35: completion waits for mem_stall to drop.
    for (int k = 1; k <= 37; k++) begin
      v = idle_in(); v.mds = (k <= 36); v.mdd = 1;
      if (k <= 29) e = e_md();
      else if (k <= 35) begin
        v.mst = 1;
        e = e_frz();
        e.busy = (k <= 32);
        e.chk_busy = (k <= 32);
      end else if (k == 36) begin
        e = e_run(); e.done = 1;
      end else e = e_run();
      apply(v, e);
    end

    // Start held off by mem_stall in IDLE, then a normal multiply.
    v = idle_in(); v.mds = 1; v.mst = 1;
    apply(v, e_frz());
    v.mst = 0;
    for (int k = 0; k < 4; k++) apply(v, e_md());
    e = e_run(); e.done = 1; apply(v, e);

    // Reset mid-divide (cnt=10 in cycle 23): aborts without md_done.
    for (int k = 1; k <= 22; k++) begin
      v = idle_in(); v.mds = 1; v.mdd = 1;
      apply(v, e_md());
    end
    v.rst_n = 0;
    apply(v, e_rst());
    apply(idle_in(), e_run());
    v = idle_in(); v.mst = 1;
    apply(v, e_frz());
    apply(idle_in(), e_run());
    apply(idle_in(), e_run());

    repeat (3) @(posedge clk);
    chk("sb_drain", 0, sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Central hazard controller for the 5-stage MIPS pipeline.
- Drives the enable/clear pins of every F/D/E/M/W pipeline register (flopenrc semantics: clear acts only while enable is high).
- Generates D- and E-stage forwarding selects.
- Sequences multi-cycle multiply/divide stalls with an internal busy timer.

## Interface
Parameters:
- MUL_CYCLES, 4, E-stage occupancy of mult/multu (≥2)
- DIV_CYCLES, 32, E-stage occupancy of div/divu (≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- rs_d, rt_d  in  5  D-stage source registers
- rs_e, rt_e  in  5  E-stage source registers
- write_reg_e, write_reg_m, write_reg_w  in  5  destination register per stage
- regwrite_e, regwrite_m, regwrite_w  in  1  destination valid per stage
- memtoreg_e, memtoreg_m  in  1  load in stage
- branch_d  in  1  conditional branch in D
- pc_redirect_d  in  1  taken branch or jump resolved in D
- md_start_e  in  1  mul/div instruction in E
- md_div_e  in  1  1=divide, 0=multiply
- mem_stall  in  1  data/instruction memory not ready
- en_f, en_d, en_e, en_m, en_w  out  1  stage register enables
- clr_d, clr_e, clr_m  out  1  stage register clears
- fwd_a_e, fwd_b_e  out  2  E-operand select: 0 regfile, 1 W result, 2 M result
- fwd_a_d, fwd_b_d  out  1  D-comparator select: 1 forward M ALU result
- md_busy  out  1  mul/div stall active
- md_done  out  1  one-cycle pulse, mul/div leaves E
- stall_cnt, flush_cnt  out  32  performance counters

## Operation
- Register 0 never matches any hazard or forward compare.
- **Forwarding** (combinational):
  - fwd_a_e=2 if regwrite_m & write_reg_m==rs_e.
  - Otherwise fwd_a_e=1 if regwrite_w & write_reg_w==rs_e.
  - Otherwise fwd_a_e=0.
  - fwd_b_e is the same using rt_e.
  - fwd_a_d = regwrite_m & write_reg_m==rs_d; fwd_b_d likewise using rt_d.
- **lwstall** = memtoreg_e & (write_reg_e==rs_d | write_reg_e==rt_d).
- **brstall** = branch_d & (regwrite_e & write_reg_e∈{rs_d,rt_d} | memtoreg_m & write_reg_m∈{rs_d,rt_d}).
- Outputs by priority, highest first:
  1. reset low: all en_*, clr_*, fwd_*, md_busy, md_done = 0.
  2. mem_stall: all en_*=0, all clr_*=0 (full freeze).
  3. md stall: en_f=en_d=en_e=0; en_m=en_w=1; clr_m=1 (bubble into M). Branch flush and lwstall are suppressed.
  4. lwstall|brstall: en_f=en_d=0; en_e=1, clr_e=1; en_m=en_w=1.
  5. pc_redirect_d: all en=1, clr_d=1.
  6. Otherwise: all en=1, clears 0.
- **md FSM** states IDLE, BUSY; 6-bit down-counter cnt.
  - IDLE & md_start_e & !mem_stall: md stall asserted; cnt←(md_div_e?DIV_CYCLES:MUL_CYCLES)−1; →BUSY.
  - BUSY & cnt≠0: md stall asserted; cnt decrements every cycle, including under mem_stall.
  - BUSY & cnt==0 & !mem_stall: no md stall; md_done=1; →IDLE. md_start_e still high this cycle is ignored, because E advances at this edge.
  - BUSY & cnt==0 & mem_stall: hold BUSY, md_done=0.
- md_busy = md stall asserted (per the FSM rules above).

## Timing
- Forwarding, enables and clears are combinational from the inputs and FSM state; there is no added latency.
- Mul/div in E: stall for exactly N cycles (N=MUL_CYCLES or DIV_CYCLES); the instruction advances at the end of cycle N+1, the md_done cycle.
- lwstall: exactly one bubble per load-use pair.
- Reset: state=IDLE, cnt=0, counters=0, applied at the first rising edge with reset low. Reset mid-BUSY aborts the operation with no md_done.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cnt increments on every non-reset cycle with en_f==0.
  - flush_cnt increments on every cycle with (clr_d&en_d)|(clr_e&en_e)|(clr_m&en_m).
  - Both counters wrap at 2^32.
- PIPE_PERF_CNT_EN undefined: the ports remain and are tied to 0; no counter flops.

## Structure
- Package pipe_ctrl_pkg holds:
  - md_state_t enum {IDLE, BUSY}
  - FWD_RF=0, FWD_W=1, FWD_M=2
  - counter width constant MD_CNT_W=6
- Sub-module md_timer: FSM, counter, md_busy, md_done.
- Hazard detection, priority mux and perf counters live in pipe_hazard_ctrl.

## Test plan
- lw $2 in E (memtoreg_e=1, write_reg_e=2), rs_d=2 -> one cycle with en_f=en_d=0, clr_e=1; next cycle all en=1.
- regwrite_m=1, write_reg_m=5, regwrite_w=1, write_reg_w=5, rs_e=5 -> fwd_a_e=2. Same with rs_e=0 -> 0.
- md_start_e=1, md_div_e=0, MUL_CYCLES=4 -> md_busy high for 4 cycles; md_done pulses in cycle 5; clr_m=1 in each of the 4 busy cycles.
- mem_stall high during div cycles 30–35 -> cnt reaches 0 and FSM holds BUSY; md_done fires on the first cycle mem_stall is low.
- pc_redirect_d=1 concurrent with lwstall -> clr_e=1, clr_d=0. Alone -> clr_d=1, en_d=1.
- Reset low mid-BUSY (cnt=10) -> next cycle IDLE, md_busy=0, stall_cnt=0 (PIPE_PERF_CNT_EN defined).
